// File: rtl/input_layer_fanout.sv
`default_nettype none
// ============================================================================
//  Module   : input_layer_fanout
//  Purpose  : Network input layer. Holds one accepted input sample and forks
//             it to NB state consumers through independently drained valid
//             bits. Jointly sinks the returning weight/delta streams, and
//             bounds forward/backward skew with an outstanding-sample credit
//             counter.
//  Options  : INPUT_LAYER_FANOUT_PERF_EN adds the oStallCycles counter port.
//  Revision : 1.0  initial release
// ============================================================================
module input_layer_fanout #(
    parameter int NC     = 7,
    parameter int NN     = 6,
    parameter int WF     = 5,
    parameter int NB     = 2,
    parameter int MAXOUT = 4,
    parameter     BURST  = "yes",
    parameter int CW     = $clog2(MAXOUT + 1)
) (
    input  logic                 iCLK,
    input  logic                 iRST,

    input  logic                 iValid_AM_Input,
    output logic                 oReady_AM_Input,
    input  logic [NC*WF-1:0]     iData_AM_Input,

    output logic [NB-1:0]        oValid_BM_State,
    input  logic [NB-1:0]        iReady_BM_State,
    output logic [NB*NC*WF-1:0]  oData_BM_State,

    input  logic                 iValid_AS_Weight,
    output logic                 oReady_AS_Weight,
    input  logic [NC*NN*WF-1:0]  iData_AS_Weight,

    input  logic                 iValid_AS_Delta0,
    output logic                 oReady_AS_Delta0,
    input  logic [NN*WF-1:0]     iData_AS_Delta0,

    output logic [CW-1:0]        oOutstanding
`ifdef INPUT_LAYER_FANOUT_PERF_EN
    ,
    output logic [31:0]          oStallCycles
`endif
);

    localparam int            c_DW       = NC * WF;
    localparam bit            c_burstEn  = (BURST == "yes");
    localparam logic [CW-1:0] c_maxOut   = CW'(MAXOUT);
    localparam logic [CW-1:0] c_one      = CW'(1);

    // Held sample, per-branch pending bits and in-flight sample counter
    logic [c_DW-1:0] r_data;
    logic [NB-1:0]   r_valid;
    logic [CW-1:0]   r_count;

    logic [NB-1:0]   w_free;
    logic            w_cntNonZero;
    logic            w_sinkFire;
    logic            w_credit;
    logic            w_inReady;
    logic            w_accept;

    // Weight and delta payloads are consumed for flow control only
    logic            w_unusedSinkData;
    assign w_unusedSinkData = ^{iData_AS_Weight, iData_AS_Delta0};

    assign w_cntNonZero = (r_count != '0);

    // A weight/delta pair is only sunk when a sample is actually in flight;
    // each ready waits on the partner stream so both are consumed together.
    assign oReady_AS_Weight = iValid_AS_Delta0 & w_cntNonZero & ~iRST;
    assign oReady_AS_Delta0 = iValid_AS_Weight & w_cntNonZero & ~iRST;
    assign w_sinkFire       = iValid_AS_Weight & iValid_AS_Delta0 & w_cntNonZero & ~iRST;

    // Branch-free and credit terms: burst mode lets a slot or credit freed in
    // this same cycle be reused immediately, sustaining one sample per cycle.
    generate
        if (c_burstEn) begin : g_burst
            assign w_free   = ~r_valid | iReady_BM_State;
            assign w_credit = (r_count < c_maxOut) | w_sinkFire;
        end else begin : g_noBurst
            assign w_free   = ~r_valid;
            assign w_credit = (r_count < c_maxOut);
        end
    endgenerate

    assign w_inReady       = (&w_free) & w_credit & ~iRST;
    assign oReady_AM_Input = w_inReady;
    assign w_accept        = iValid_AM_Input & w_inReady;

    // Every branch sees the same held sample
    generate
        for (genvar b = 0; b < NB; b++) begin : g_branch
            assign oData_BM_State[b*c_DW +: c_DW] = r_data;
        end
    endgenerate

    assign oValid_BM_State = r_valid;
    assign oOutstanding    = r_count;

    // Capture accepted samples; otherwise retire each branch as it drains
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_data  <= '0;
            r_valid <= '0;
        end else if (w_accept) begin
            r_data  <= iData_AM_Input;
            r_valid <= '1;
        end else begin
            r_valid <= r_valid & ~iReady_BM_State;
        end
    end

    // Track samples in flight: +1 on accept, -1 on sink, unchanged on both
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_count <= '0;
        end else begin
            case ({w_accept, w_sinkFire})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef INPUT_LAYER_FANOUT_PERF_EN
    logic [31:0] r_stallCycles;

    // Saturating count of cycles where a sample is offered but refused
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_stallCycles <= '0;
        end else if (iValid_AM_Input && !w_inReady && (r_stallCycles != '1)) begin
            r_stallCycles <= r_stallCycles + 32'd1;
        end
    end

    assign oStallCycles = r_stallCycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_layer_fanout.sv
`default_nettype none
// ============================================================================
//  Module   : tb_input_layer_fanout
//  Purpose  : Scoreboard bench for input_layer_fanout (NB=2, MAXOUT=4,
//             BURST="yes"). Stimulus pushes expected samples per branch; a
//             negedge monitor pops and compares on every branch handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_input_layer_fanout;

    localparam int NC = 7, NN = 6, WF = 5, NB = 2, MAXOUT = 4;
    localparam int DW = NC * WF;
    localparam int CW = $clog2(MAXOUT + 1);

    logic               clk;
    logic               rst;
    logic               inValid;
    logic               inReady;
    logic [DW-1:0]      inData;
    logic [NB-1:0]      stValid;
    logic [NB-1:0]      stReady;
    logic [NB*DW-1:0]   stData;
    logic               wValid, wReady;
    logic [NC*NN*WF-1:0] wData;
    logic               dValid, dReady;
    logic [NN*WF-1:0]   dData;
    logic [CW-1:0]      outstanding;
`ifdef INPUT_LAYER_FANOUT_PERF_EN
    logic [31:0]        stallCycles;
`endif

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    input_layer_fanout #(
        .NC(NC), .NN(NN), .WF(WF), .NB(NB), .MAXOUT(MAXOUT), .BURST("yes")
    ) dut (
        .iCLK             (clk),
        .iRST             (rst),
        .iValid_AM_Input  (inValid),
        .oReady_AM_Input  (inReady),
        .iData_AM_Input   (inData),
        .oValid_BM_State  (stValid),
        .iReady_BM_State  (stReady),
        .oData_BM_State   (stData),
        .iValid_AS_Weight (wValid),
        .oReady_AS_Weight (wReady),
        .iData_AS_Weight  (wData),
        .iValid_AS_Delta0 (dValid),
        .oReady_AS_Delta0 (dReady),
        .iData_AS_Delta0  (dData),
        .oOutstanding     (outstanding)
`ifdef INPUT_LAYER_FANOUT_PERF_EN
        ,
        .oStallCycles     (stallCycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every branch handshake must deliver the oldest expected sample
    always @(negedge clk) begin
        if (!rst) begin
            if (stValid[0] && stReady[0]) begin
                if (q0.size() == 0) begin
                    chk("branch0_unexpected", {29'd0, stData[0 +: DW]}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("branch0_data", {29'd0, stData[0 +: DW]}, {29'd0, q0.pop_front()});
                end
            end
            if (stValid[1] && stReady[1]) begin
                if (q1.size() == 0) begin
                    chk("branch1_unexpected", {29'd0, stData[DW +: DW]}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("branch1_data", {29'd0, stData[DW +: DW]}, {29'd0, q1.pop_front()});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample for one cycle; expectations are hand-computed
    task automatic offer(input logic [DW-1:0] data, input logic expAcc,
                         input int expCnt, input logic [NB-1:0] expV);
        inValid = 1'b1;
        inData  = data;
        @(negedge clk);
        chk("in_ready", {63'd0, inReady}, {63'd0, expAcc});
        chk("outstanding", {61'd0, outstanding}, 64'(expCnt));
        chk("state_valid", {62'd0, stValid}, {62'd0, expV});
        if (expAcc) begin
            q0.push_back(data);
            q1.push_back(data);
        end
        step();
        inValid = 1'b0;
    endtask

    // One cycle with no input offered; checks counter and sink readies
    task automatic idle(input int expCnt, input logic expWR, input logic expDR);
        inValid = 1'b0;
        @(negedge clk);
        chk("idle_outstanding", {61'd0, outstanding}, 64'(expCnt));
        chk("weight_ready", {63'd0, wReady}, {63'd0, expWR});
        chk("delta_ready", {63'd0, dReady}, {63'd0, expDR});
        step();
    endtask

    initial begin
        rst = 1'b1; inValid = 1'b1; inData = '0; stReady = 2'b11;
        wValid = 1'b1; dValid = 1'b1; wData = '1; dData = '1;
        step();
        // Reset state with every valid raised
        @(negedge clk);
        chk("rst_in_ready", {63'd0, inReady}, 64'd0);
        chk("rst_state_valid", {62'd0, stValid}, 64'd0);
        chk("rst_outstanding", {61'd0, outstanding}, 64'd0);
        chk("rst_weight_ready", {63'd0, wReady}, 64'd0);
        chk("rst_delta_ready", {63'd0, dReady}, 64'd0);
        step();
        rst = 1'b0; inValid = 1'b0; wValid = 1'b0; dValid = 1'b0;

        // Back-to-back samples until the credit limit stalls the input
        offer(35'h01, 1'b1, 0, 2'b00);
        offer(35'h02, 1'b1, 1, 2'b11);
        offer(35'h03, 1'b1, 2, 2'b11);
        offer(35'h04, 1'b1, 3, 2'b11);
        offer(35'h05, 1'b0, 4, 2'b11);
        // Sink pairs free one credit per cycle, refilled the same cycle
        wValid = 1'b1; dValid = 1'b1;
        offer(35'h05, 1'b1, 4, 2'b00);
        offer(35'h06, 1'b1, 4, 2'b11);
        offer(35'h07, 1'b1, 4, 2'b11);
        offer(35'h08, 1'b1, 4, 2'b11);
        idle(4, 1'b1, 1'b1);
        idle(3, 1'b1, 1'b1);
        idle(2, 1'b1, 1'b1);
        idle(1, 1'b1, 1'b1);
        // Empty counter stalls the sink
        idle(0, 1'b0, 1'b0);
        idle(0, 1'b0, 1'b0);
        offer(35'h0A, 1'b1, 0, 2'b00);
        idle(1, 1'b1, 1'b1);
        idle(0, 1'b0, 1'b0);
        wValid = 1'b0; dValid = 1'b0;

        // Branch 1 holds off for three cycles after sample 0x11
        stReady = 2'b01;
        offer(35'h11, 1'b1, 0, 2'b00);
        offer(35'h12, 1'b0, 1, 2'b11);
        offer(35'h12, 1'b0, 1, 2'b10);
        offer(35'h12, 1'b0, 1, 2'b10);
        stReady = 2'b11;
        offer(35'h12, 1'b1, 1, 2'b10);

        // Weight alone waits for delta, then the pair fires together
        wValid = 1'b1;
        idle(2, 1'b0, 1'b1);
        dValid = 1'b1;
        idle(2, 1'b1, 1'b1);
        wValid = 1'b0; dValid = 1'b0;
        idle(1, 1'b0, 1'b0);

        // Build V=2'b10, CNT=3, then reset mid-transfer
        offer(35'h20, 1'b1, 1, 2'b00);
        idle(2, 1'b0, 1'b0);
        stReady = 2'b01;
        offer(35'h21, 1'b1, 2, 2'b00);
        idle(3, 1'b0, 1'b0);
        rst = 1'b1; inValid = 1'b1; inData = 35'h22; wValid = 1'b1; dValid = 1'b1;
        @(negedge clk);
        chk("rstmid_state_valid", {62'd0, stValid}, 64'd2);
        chk("rstmid_outstanding", {61'd0, outstanding}, 64'd3);
        chk("rstmid_in_ready", {63'd0, inReady}, 64'd0);
        chk("rstmid_weight_ready", {63'd0, wReady}, 64'd0);
        chk("rstmid_delta_ready", {63'd0, dReady}, 64'd0);
`ifdef INPUT_LAYER_FANOUT_PERF_EN
        chk("stall_cycles", {32'd0, stallCycles}, 64'd4);
`endif
        q1.delete();
        step();
        rst = 1'b0; inValid = 1'b0; wValid = 1'b0; dValid = 1'b0; stReady = 2'b11;
        @(negedge clk);
        chk("post_rst_state_valid", {62'd0, stValid}, 64'd0);
        chk("post_rst_outstanding", {61'd0, outstanding}, 64'd0);
`ifdef INPUT_LAYER_FANOUT_PERF_EN
        chk("post_rst_stall_cycles", {32'd0, stallCycles}, 64'd0);
`endif
        step();
        idle(0, 1'b0, 1'b0);

        chk("branch0_drained", 64'(q0.size()), 64'd0);
        chk("branch1_drained", 64'(q1.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
